imu_spi_seq: RTL
================

# imu_spi_seq

Sequencer that owns the 16-bit SPI master on the inertial-sensor link. After reset it waits a power-up holdoff and issues a fixed four-command initialization sequence to the gyro. It then services the sensor's data-ready interrupt by reading the yaw-rate low and high bytes and presenting a signed 16-bit yaw rate with a one-cycle valid strobe. It sits between the SPI master (command/done handshake) and the heading/PID logic (yaw_rt/vld consumer).

## Interface
- INIT_WAIT, 16'hFFFF, holdoff cycles after reset before the first SPI command (16-bit, minimum 1)
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- INT  in  1  sensor data-ready, asynchronous, active-high, level
- spi_done  in  1  SPI master transaction-complete pulse
- spi_rd_data  in  16  SPI master read word; only [7:0] used
- spi_wrt  out  1  one-cycle start pulse to SPI master
- spi_cmd  out  16  command word to SPI master
- yaw_rt  out  16  assembled yaw rate {high byte, low byte}, two's complement
- vld  out  1  one-cycle strobe, yaw_rt updated
- init_done  out  1  high once the init sequence is complete; sticky until reset

## Operation
- States: HOLD, INIT_WR, INIT_WT, IDLE, RDL_WR, RDL_WT, RDH_WR, RDH_WT, VLD.
- HOLD: 16-bit timer counts up from 0. Go to INIT_WR when timer == INIT_WAIT-1.
- INIT_WR: pulse spi_wrt with spi_cmd = INIT_CMD[idx]; idx is a 2-bit counter, 0 after reset. Go to INIT_WT.
- INIT_WT: wait for spi_done, then idx+1 -> INIT_WR. On idx==3 instead set init_done -> IDLE.
- Init commands, in order: 16'h0D02, 16'h1160, 16'h1440, 16'h1500.
- IDLE: when synchronized INT (2-flop sync) is 1 -> RDL_WR.
- RDL_WR: pulse spi_wrt, spi_cmd = 16'hA600 -> RDL_WT. On spi_done, load yaw_rt[7:0] <= spi_rd_data[7:0] -> RDH_WR.
- RDH_WR: pulse spi_wrt, spi_cmd = 16'hA700 -> RDH_WT. On spi_done, load yaw_rt[15:8] <= spi_rd_data[7:0] -> VLD.
- VLD: vld=1 for exactly this cycle -> IDLE.
- INT is level-sensitive. If INT is still high in IDLE, a new read pair starts immediately. INT edges during a read are not latched.
- spi_done outside a *_WT state is ignored.
- yaw_rt holds its value between updates. The low byte changes mid-pair. The consumer samples only on vld.

## Timing
- Reset values: spi_wrt 0, spi_cmd 16'h0000, yaw_rt 16'h0000, vld 0, init_done 0. State HOLD, timer 0, idx 0, sync flops 0.
- Reset asserted mid-transaction: block returns to HOLD and reruns holdoff plus full init. The SPI master shares rst_n.
- First spi_wrt is high in cycle INIT_WAIT, counting the first posedge with rst_n=1 as cycle 0.
- spi_wrt is registered, high exactly one cycle per transaction, never while a transaction is outstanding.
- spi_cmd is registered. It is valid in the spi_wrt cycle and held until the next spi_wrt.
- Next spi_wrt is no earlier than the cycle after spi_done is seen (two cycles after the done edge).
- INT-to-RDL spi_wrt: 3 cycles from INT rising at a posedge (2 sync + 1 state).
- Read pair completion (high-byte spi_done) to vld: 1 cycle.

## Structure
- Shared package imu_pkg holds:
  - the state enum typedef;
  - the INIT_CMD array constant;
  - RD_YAW_L = 16'hA600 and RD_YAW_H = 16'hA700.
- Sub-module int_sync: 2-flop synchronizer, clk/rst_n/async in/sync out, reset to 0, reusable for other sensor pins.
- Timer, idx counter and FSM stay in imu_spi_seq.

## Test plan
- Bench setup: INIT_WAIT=8, and a behavioral SPI master model that pulses spi_done 20 cycles after spi_wrt and returns programmed rd_data.
- Reset release -> spi_wrt first high in cycle 8 with spi_cmd 16'h0D02. Then 16'h1160, 16'h1440, 16'h1500, each wrt 2 cycles after the prior done. init_done rises the cycle after the 4th done.
- After init, INT high with model returning 16'h00CD then 16'h00AB -> commands A600, A700 in order. vld one cycle with yaw_rt 16'hABCD.
- High-byte 8'hFF, low 8'h38 -> yaw_rt 16'hFF38 (-200). vld width exactly 1.
- INT held high for 100 cycles -> back-to-back read pairs. No spi_wrt overlaps an outstanding transaction. vld once per pair.
- INT pulses high before init_done -> no read issued during init. Reads begin only if INT is high after init_done.
- rst_n low for one cycle during RDH_WT -> all outputs return to reset values next cycle. Holdoff and init rerun; a stray spi_done during HOLD is ignored.

Source files
------------

// File: rtl/imu_pkg.sv
// -----------------------------------------------------------------------------
// imu_pkg
// Shared definitions for the inertial-sensor SPI sequencer:
//   - imu_state_e : sequencer state encoding
//   - INIT_CMD    : gyro initialization command words, issued index 0 first
//   - RD_YAW_L/H  : read commands for the yaw-rate low and high bytes
//   - init_cmd_at : lookup helper for the init command table
// -----------------------------------------------------------------------------
package imu_pkg;

    typedef enum logic [3:0] {
        HOLD    = 4'd0,
        INIT_WR = 4'd1,
        INIT_WT = 4'd2,
        IDLE    = 4'd3,
        RDL_WR  = 4'd4,
        RDL_WT  = 4'd5,
        RDH_WR  = 4'd6,
        RDH_WT  = 4'd7,
        VLD     = 4'd8
    } imu_state_e;

    // Packed so that INIT_CMD[0] is the first command sent.
    localparam logic [3:0][15:0] INIT_CMD = {16'h1500, 16'h1440, 16'h1160, 16'h0D02};

    localparam logic [15:0] RD_YAW_L = 16'hA600;
    localparam logic [15:0] RD_YAW_H = 16'hA700;

    function automatic logic [15:0] init_cmd_at(input logic [1:0] idx);
        return INIT_CMD[idx];
    endfunction

endpackage

// File: rtl/int_sync.sv
// -----------------------------------------------------------------------------
// int_sync
// Two-flop synchronizer for a single asynchronous sensor pin.
// Ports:
//   clk      in  system clock
//   rst_n    in  synchronous active-low reset, clears both flops to 0
//   async_in in  asynchronous level input
//   sync_out out async_in delayed by two clk edges, safe to use in clk domain
// -----------------------------------------------------------------------------
module int_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous pin into the clk domain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= async_in;
            sync_r <= meta_r;
        end
    end

    assign sync_out = sync_r;

endmodule

// File: rtl/imu_spi_seq.sv
// -----------------------------------------------------------------------------
// imu_spi_seq
// Owns the 16-bit SPI master on the inertial-sensor link. After reset it waits
// INIT_WAIT cycles, sends the four gyro init commands, then reads the yaw-rate
// low/high bytes whenever the (synchronized) data-ready pin is high and
// presents the signed 16-bit result with a one-cycle strobe.
//
// Parameters:
//   INIT_WAIT   holdoff cycles after reset before the first command (>= 1)
// Ports:
//   clk         in   system clock, all logic on posedge
//   rst_n       in   synchronous active-low reset
//   INT         in   sensor data-ready, asynchronous level, active-high
//   spi_done    in   SPI master transaction-complete pulse
//   spi_rd_data in   SPI master read word, only [7:0] carries data
//   spi_wrt     out  one-cycle start pulse to the SPI master (registered)
//   spi_cmd     out  command word, valid with spi_wrt and held until the next
//   yaw_rt      out  {high byte, low byte} yaw rate, two's complement
//   vld         out  one-cycle strobe, yaw_rt holds a complete new sample
//   init_done   out  sticky flag, init sequence finished
// -----------------------------------------------------------------------------
module imu_spi_seq
    import imu_pkg::*;
#(
    parameter logic [15:0] INIT_WAIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    output logic [15:0] yaw_rt,
    output logic        vld,
    output logic        init_done
);

    imu_state_e  state_r;
    imu_state_e  state_nxt_s;
    logic [15:0] timer_r;
    logic [15:0] timer_nxt_s;
    logic [1:0]  idx_r;
    logic [1:0]  idx_nxt_s;
    logic        int_sync_s;

    logic        spi_wrt_r;
    logic [15:0] spi_cmd_r;
    logic [15:0] yaw_rt_r;
    logic        vld_r;
    logic        init_done_r;

    logic        wrt_s;
    logic [15:0] cmd_s;
    logic        ld_lo_s;
    logic        ld_hi_s;
    logic        vld_s;
    logic        done_set_s;

    // The sensor only returns a byte; the upper half of the read word is unused.
    logic        rd_hi_unused_s;
    assign rd_hi_unused_s = ^spi_rd_data[15:8];

    int_sync u_int_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (INT),
        .sync_out (int_sync_s)
    );

    // State, holdoff timer and init-command index registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= HOLD;
            timer_r <= 16'd0;
            idx_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Next-state logic and per-state actions. The SPI start pulse and command
    // are produced while in a *_WR state and registered, so spi_wrt is high in
    // the cycle after the *_WR state. vld is registered on the transition into
    // VLD so the strobe coincides with that state.
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        idx_nxt_s   = idx_r;
        wrt_s       = 1'b0;
        cmd_s       = spi_cmd_r;
        ld_lo_s     = 1'b0;
        ld_hi_s     = 1'b0;
        vld_s       = 1'b0;
        done_set_s  = 1'b0;
        case (state_r)
            HOLD: begin
                if (timer_r == (INIT_WAIT - 16'd1)) begin
                    state_nxt_s = INIT_WR;
                end else begin
                    timer_nxt_s = timer_r + 16'd1;
                end
            end
            INIT_WR: begin
                wrt_s       = 1'b1;
                cmd_s       = init_cmd_at(idx_r);
                state_nxt_s = INIT_WT;
            end
            INIT_WT: begin
                if (spi_done) begin
                    if (idx_r == 2'd3) begin
                        done_set_s  = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        idx_nxt_s   = idx_r + 2'd1;
                        state_nxt_s = INIT_WR;
                    end
                end else begin
                    state_nxt_s = INIT_WT;
                end
            end
            IDLE: begin
                // Level-sensitive: a still-high INT starts the next pair at once.
                if (int_sync_s) begin
                    state_nxt_s = RDL_WR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RDL_WR: begin
                wrt_s       = 1'b1;
                cmd_s       = RD_YAW_L;
                state_nxt_s = RDL_WT;
            end
            RDL_WT: begin
                if (spi_done) begin
                    ld_lo_s     = 1'b1;
                    state_nxt_s = RDH_WR;
                end else begin
                    state_nxt_s = RDL_WT;
                end
            end
            RDH_WR: begin
                wrt_s       = 1'b1;
                cmd_s       = RD_YAW_H;
                state_nxt_s = RDH_WT;
            end
            RDH_WT: begin
                if (spi_done) begin
                    ld_hi_s     = 1'b1;
                    vld_s       = 1'b1;
                    state_nxt_s = VLD;
                end else begin
                    state_nxt_s = RDH_WT;
                end
            end
            VLD: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = HOLD;
            end
        endcase
    end

    // Registered SPI handshake outputs; spi_cmd holds between start pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            spi_wrt_r <= 1'b0;
            spi_cmd_r <= 16'h0000;
        end else begin
            spi_wrt_r <= wrt_s;
            spi_cmd_r <= cmd_s;
        end
    end

    // Yaw-rate assembly: each byte loads on its own spi_done; value holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            yaw_rt_r <= 16'h0000;
        end else begin
            if (ld_lo_s) begin
                yaw_rt_r[7:0] <= spi_rd_data[7:0];
            end
            if (ld_hi_s) begin
                yaw_rt_r[15:8] <= spi_rd_data[7:0];
            end
        end
    end

    // Consumer strobe and sticky init flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_r       <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            vld_r <= vld_s;
            if (done_set_s) begin
                init_done_r <= 1'b1;
            end
        end
    end

    assign spi_wrt   = spi_wrt_r;
    assign spi_cmd   = spi_cmd_r;
    assign yaw_rt    = yaw_rt_r;
    assign vld       = vld_r;
    assign init_done = init_done_r;

endmodule
